// File: rtl/alarm_time_editor_if.sv
// alarm_time_editor_if: edit, compare and ring signals between the mode picker, clock and alarm editor
interface alarm_time_editor_if;
  logic       en;
  logic [3:0] sel;
  logic       inc;
  logic       dec;
  logic       alarm_on;
  logic       min_tick;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] alm_hour;
  logic [7:0] alm_min;
  logic       ring;
  modport master (output en, sel, inc, dec, alarm_on, min_tick, cur_hour, cur_min,
                  input alm_hour, alm_min, ring);
  modport slave  (input en, sel, inc, dec, alarm_on, min_tick, cur_hour, cur_min,
                  output alm_hour, alm_min, ring);
endinterface

// File: rtl/alarm_time_editor.sv
// alarm_time_editor: BCD alarm HH:MM digit editor with per-minute compare and timed ring
module alarm_time_editor #(
  parameter logic [7:0] RST_HOUR     = 8'h07,
  parameter logic [7:0] RST_MIN      = 8'h00,
  parameter int         RING_MINUTES = 1
) (
  input logic clk,
  input logic rst,
  alarm_time_editor_if.slave bus
);
  typedef enum logic {IDLE, RINGING} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] hour_q, hour_d, min_q, min_d;
  logic       inc_p_q, inc_p_d, dec_p_q, dec_p_d, ring_q, ring_d;
  logic       inc_e, dec_e, btn, ringing, edit, match;
  function automatic logic [3:0] step(input logic [3:0] d, input logic [3:0] mx, input logic up);
    return up ? (d == mx ? 4'd0 : d + 4'd1) : (d == 4'd0 ? mx : d - 4'd1);
  endfunction
  assign inc_e   = bus.inc & ~inc_p_q;
  assign dec_e   = bus.dec & ~dec_p_q;
  assign btn     = inc_e | dec_e;
  assign ringing = state_q == RINGING;
  assign edit    = bus.en & $onehot(bus.sel) & (inc_e ^ dec_e) & ~(ringing & btn);
  assign match   = bus.min_tick & bus.alarm_on & (bus.cur_hour == hour_q) & (bus.cur_min == min_q);
  // next-state: button history, digit edits with hour-tens clamping, ring FSM and counter
  always_comb begin
    inc_p_d = bus.inc;
    dec_p_d = bus.dec;
    hour_d  = hour_q;
    min_d   = min_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (edit) begin
      if (bus.sel[0]) min_d[3:0] = step(min_q[3:0], 4'd9, inc_e);
      if (bus.sel[1]) min_d[7:4] = step(min_q[7:4], 4'd5, inc_e);
      if (bus.sel[2]) hour_d[3:0] = step(hour_q[3:0], hour_q[7:4] == 4'd2 ? 4'd3 : 4'd9, inc_e);
      if (bus.sel[3]) begin
        hour_d[7:4] = step(hour_q[7:4], 4'd2, inc_e);
        if (hour_d[7:4] == 4'd2 && hour_q[3:0] > 4'd3) hour_d[3:0] = 4'd3;
      end
    end
    if (ringing) begin
      if (btn || !bus.alarm_on || (bus.min_tick && cnt_q == 4'd1)) state_d = IDLE;
      else if (bus.min_tick) cnt_d = cnt_q - 4'd1;
    end else if (match) begin
      state_d = RINGING;
      cnt_d   = 4'(RING_MINUTES);
    end
    ring_d = state_d == RINGING;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      inc_p_q <= 1'b0;
      dec_p_q <= 1'b0;
      hour_q  <= RST_HOUR;
      min_q   <= RST_MIN;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ring_q  <= 1'b0;
    end else begin
      inc_p_q <= inc_p_d;
      dec_p_q <= dec_p_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ring_q  <= ring_d;
    end
  end
  assign bus.alm_hour = hour_q;
  assign bus.alm_min  = min_q;
  assign bus.ring     = ring_q;
endmodule

// File: tb/tb_alarm_time_editor.sv
// tb_alarm_time_editor: table-driven edit vectors plus directed ring/reset sequences
module tb_alarm_time_editor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  alarm_time_editor_if bus();
  alarm_time_editor #(.RST_HOUR(8'h07), .RST_MIN(8'h00), .RING_MINUTES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       en;
    logic [3:0] sel;
    logic       inc;
    logic       dec;
    logic [7:0] hour;
    logic [7:0] min;
  } vec_t;
  vec_t v[24];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic press(input logic i, input logic d);
    bus.inc = i;
    bus.dec = d;
    tick();
    bus.inc = 1'b0;
    bus.dec = 1'b0;
    tick();
  endtask
  task automatic minute(input logic [7:0] h, input logic [7:0] m);
    bus.cur_hour = h;
    bus.cur_min  = m;
    bus.min_tick = 1'b1;
    tick();
    bus.min_tick = 1'b0;
  endtask
  initial begin
    v[0]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h07, 8'h11};
    v[1]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h07, 8'h21};
    v[2]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h07, 8'h31};
    v[3]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h07, 8'h41};
    v[4]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h07, 8'h51};
    v[5]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 8'h07, 8'h50};
    v[6]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 8'h07, 8'h00};
    v[7]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 8'h07, 8'h50};
    v[8]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 8'h07, 8'h59};
    v[9]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h07, 8'h50};
    v[10] = '{1'b1, 4'b0100, 1'b1, 1'b0, 8'h08, 8'h50};
    v[11] = '{1'b1, 4'b0100, 1'b1, 1'b0, 8'h09, 8'h50};
    v[12] = '{1'b1, 4'b1000, 1'b1, 1'b0, 8'h19, 8'h50};
    v[13] = '{1'b1, 4'b1000, 1'b1, 1'b0, 8'h23, 8'h50};
    v[14] = '{1'b1, 4'b0100, 1'b1, 1'b0, 8'h20, 8'h50};
    v[15] = '{1'b1, 4'b0100, 1'b0, 1'b1, 8'h23, 8'h50};
    v[16] = '{1'b1, 4'b1000, 1'b1, 1'b0, 8'h03, 8'h50};
    v[17] = '{1'b1, 4'b1000, 1'b0, 1'b1, 8'h23, 8'h50};
    v[18] = '{1'b1, 4'b0000, 1'b1, 1'b0, 8'h23, 8'h50};
    v[19] = '{1'b1, 4'b0011, 1'b1, 1'b0, 8'h23, 8'h50};
    v[20] = '{1'b0, 4'b0001, 1'b1, 1'b0, 8'h23, 8'h50};
    v[21] = '{1'b1, 4'b0001, 1'b1, 1'b1, 8'h23, 8'h50};
    v[22] = '{1'b1, 4'b1000, 1'b0, 1'b1, 8'h13, 8'h50};
    v[23] = '{1'b1, 4'b0100, 1'b1, 1'b0, 8'h14, 8'h50};
    bus.en = 1'b0; bus.sel = 4'b0000; bus.inc = 1'b0; bus.dec = 1'b0;
    bus.alarm_on = 1'b0; bus.min_tick = 1'b0; bus.cur_hour = 8'h00; bus.cur_min = 8'h00;
    tick();
    tick();
    rst = 1'b1;
    check("reset_hour", bus.alm_hour, 8'h07);
    check("reset_min", bus.alm_min, 8'h00);
    check("reset_ring", {7'd0, bus.ring}, 8'h00);
    bus.en = 1'b1; bus.sel = 4'b0001; bus.inc = 1'b1;
    repeat (20) tick();
    bus.inc = 1'b0;
    tick();
    check("hold_single_edge", bus.alm_min, 8'h01);
    for (int i = 0; i < 24; i++) begin
      bus.en  = v[i].en;
      bus.sel = v[i].sel;
      press(v[i].inc, v[i].dec);
      check($sformatf("vec%0d_hour", i), bus.alm_hour, v[i].hour);
      check($sformatf("vec%0d_min", i), bus.alm_min, v[i].min);
    end
    bus.en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_hour", bus.alm_hour, 8'h07);
    check("rst2_min", bus.alm_min, 8'h00);
    bus.alarm_on = 1'b1;
    minute(8'h07, 8'h05);
    check("no_match_ring", {7'd0, bus.ring}, 8'h00);
    minute(8'h07, 8'h00);
    check("match_ring", {7'd0, bus.ring}, 8'h01);
    tick();
    check("ring_hold", {7'd0, bus.ring}, 8'h01);
    minute(8'h07, 8'h01);
    check("ring_tick1", {7'd0, bus.ring}, 8'h01);
    minute(8'h07, 8'h02);
    check("ring_tick2_off", {7'd0, bus.ring}, 8'h00);
    minute(8'h07, 8'h00);
    check("rematch_ring", {7'd0, bus.ring}, 8'h01);
    bus.en = 1'b1; bus.sel = 4'b0001; bus.inc = 1'b1;
    tick();
    check("silence_ring", {7'd0, bus.ring}, 8'h00);
    check("silence_no_edit", bus.alm_min, 8'h00);
    bus.inc = 1'b0;
    tick();
    press(1'b1, 1'b0);
    check("edit_after_silence", bus.alm_min, 8'h01);
    bus.en = 1'b0;
    minute(8'h07, 8'h01);
    check("match_0701", {7'd0, bus.ring}, 8'h01);
    bus.alarm_on = 1'b0;
    tick();
    check("alarm_off_stop", {7'd0, bus.ring}, 8'h00);
    bus.alarm_on = 1'b1;
    minute(8'h07, 8'h01);
    check("match_again", {7'd0, bus.ring}, 8'h01);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_ring", {7'd0, bus.ring}, 8'h00);
    check("rst_hour", bus.alm_hour, 8'h07);
    check("rst_min", bus.alm_min, 8'h00);
    bus.alarm_on = 1'b0;
    minute(8'h07, 8'h00);
    check("disarmed_match", {7'd0, bus.ring}, 8'h00);
    tick();
    check("disarmed_hold", {7'd0, bus.ring}, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
